alu_rs: RTL

Reservation station and issue scheduler for the integer ALU. It accepts one decoded instruction per cycle from dispatch and holds it until both source operands are available. Operands are woken by snooping the two common data buses (ALU result and load/store buffer result). Each cycle it issues at most one ready entry into the ALU through registered operand outputs, so the combinational ALU is shared by all buffered instructions. It sits between dispatch/ROB and the ALU.

---
 rtl/alu_rs.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched ops until both
// operands are captured from the CDBs, then issues one ready entry per cycle.
module alu_rs #(
  parameter int DEPTH = 8,
  parameter int OP_W  = 6,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  // Dispatch handshake: in_valid is taken on an edge with rdy=1, clr=0 and
  // out_full=0; the dispatcher must keep in_valid low while out_full is high.
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [31:0]      in_v1,
  input  logic [31:0]      in_v2,
  input  logic [TAG_W-1:0] in_q1,
  input  logic [TAG_W-1:0] in_q2,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [TAG_W-1:0] in_rob_tag,
  output logic             out_full,
  input  logic [TAG_W-1:0] cdb_alu_tag,
  input  logic [31:0]      cdb_alu_value,
  input  logic [TAG_W-1:0] cdb_lsb_tag,
  input  logic [31:0]      cdb_lsb_value,
  output logic [OP_W-1:0]  out_op,
  output logic [31:0]      out_value1,
  output logic [31:0]      out_value2,
  output logic [31:0]      out_imm,
  output logic [31:0]      out_pc,
  output logic [TAG_W-1:0] out_rob_tag
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [OP_W-1:0]  op_q  [DEPTH], op_d  [DEPTH];
  logic [31:0]      v1_q  [DEPTH], v1_d  [DEPTH];
  logic [31:0]      v2_q  [DEPTH], v2_d  [DEPTH];
  logic [TAG_W-1:0] q1_q  [DEPTH], q1_d  [DEPTH];
  logic [TAG_W-1:0] q2_q  [DEPTH], q2_d  [DEPTH];
  logic [31:0]      imm_q [DEPTH], imm_d [DEPTH];
  logic [31:0]      pc_q  [DEPTH], pc_d  [DEPTH];
  logic [TAG_W-1:0] rob_q [DEPTH], rob_d [DEPTH];

  logic [OP_W-1:0]  out_op_q, out_op_d;
  logic [31:0]      out_v1_q, out_v1_d;
  logic [31:0]      out_v2_q, out_v2_d;
  logic [31:0]      out_imm_q, out_imm_d;
  logic [31:0]      out_pc_q, out_pc_d;
  logic [TAG_W-1:0] out_rob_q, out_rob_d;

  logic [DEPTH-1:0] ready;
  logic             iss_hit, free_hit;
  logic [IDX_W-1:0] iss_idx, free_idx;

  // Operand capture from the CDBs; the ALU bus wins when both tags match.
  function automatic logic [TAG_W+31:0] capture(input logic [TAG_W-1:0] q,
                                                 input logic [31:0]      v);
    logic [TAG_W+31:0] r;
    r = {q, v};
    if (q != '0 && q == cdb_alu_tag)      r = {{TAG_W{1'b0}}, cdb_alu_value};
    else if (q != '0 && q == cdb_lsb_tag) r = {{TAG_W{1'b0}}, cdb_lsb_value};
    return r;
  endfunction

  assign out_full = &busy_q;

  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++)
      ready[i] = busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
  end

  // Priority pickers scan downward so the lowest index wins.
  always_comb begin
    iss_hit  = 1'b0;
    iss_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        iss_hit = 1'b1;
        iss_idx = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]  = op_q[i];
      v1_d[i]  = v1_q[i];
      v2_d[i]  = v2_q[i];
      q1_d[i]  = q1_q[i];
      q2_d[i]  = q2_q[i];
      imm_d[i] = imm_q[i];
      pc_d[i]  = pc_q[i];
      rob_d[i] = rob_q[i];
    end
    out_op_d  = '0;
    out_v1_d  = '0;
    out_v2_d  = '0;
    out_imm_d = '0;
    out_pc_d  = '0;
    out_rob_d = '0;

    if (clr) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i]) begin
          {q1_d[i], v1_d[i]} = capture(q1_q[i], v1_q[i]);
          {q2_d[i], v2_d[i]} = capture(q2_q[i], v2_q[i]);
        end
      end

      if (iss_hit) begin
        busy_d[iss_idx] = 1'b0;
        out_op_d  = op_q[iss_idx];
        out_v1_d  = v1_q[iss_idx];
        out_v2_d  = v2_q[iss_idx];
        out_imm_d = imm_q[iss_idx];
        out_pc_d  = pc_q[iss_idx];
        out_rob_d = rob_q[iss_idx];
      end

      // The free slot comes from start-of-cycle state, so a slot vacated by
      // this edge's issue is never the dispatch target.
      if (in_valid && free_hit) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = in_op;
        imm_d[free_idx]  = in_imm;
        pc_d[free_idx]   = in_pc;
        rob_d[free_idx]  = in_rob_tag;
        {q1_d[free_idx], v1_d[free_idx]} = capture(in_q1, in_v1);
        {q2_d[free_idx], v2_d[free_idx]} = capture(in_q2, in_v2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        rob_q[i] <= '0;
      end
      out_op_q  <= '0;
      out_v1_q  <= '0;
      out_v2_q  <= '0;
      out_imm_q <= '0;
      out_pc_q  <= '0;
      out_rob_q <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= op_d[i];
        v1_q[i]  <= v1_d[i];
        v2_q[i]  <= v2_d[i];
        q1_q[i]  <= q1_d[i];
        q2_q[i]  <= q2_d[i];
        imm_q[i] <= imm_d[i];
        pc_q[i]  <= pc_d[i];
        rob_q[i] <= rob_d[i];
      end
      out_op_q  <= out_op_d;
      out_v1_q  <= out_v1_d;
      out_v2_q  <= out_v2_d;
      out_imm_q <= out_imm_d;
      out_pc_q  <= out_pc_d;
      out_rob_q <= out_rob_d;
    end
  end

  assign out_op      = out_op_q;
  assign out_value1  = out_v1_q;
  assign out_value2  = out_v2_q;
  assign out_imm     = out_imm_q;
  assign out_pc      = out_pc_q;
  assign out_rob_tag = out_rob_q;

endmodule
